// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider and the EX-stage HI/LO split.
package div_unit_pkg;

    localparam int unsigned DIV_DATA_W   = 32;
    localparam int unsigned DIV_RESULT_W = 2 * DIV_DATA_W;
    localparam int unsigned DIV_WORK_W   = 2 * DIV_DATA_W + 1;
    localparam int unsigned DIV_STEPS    = 32;
    localparam int unsigned DIV_CNT_W    = 6;

    // Result field positions: remainder goes to HI, quotient to LO
    localparam int unsigned DIV_REM_MSB = 63;
    localparam int unsigned DIV_REM_LSB = 32;
    localparam int unsigned DIV_QUO_MSB = 31;
    localparam int unsigned DIV_QUO_LSB = 0;

    localparam logic [DIV_RESULT_W-1:0] DIV_RESULT_ZERO = 64'h0;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    typedef struct packed {
        logic [DIV_DATA_W-1:0] rem;
        logic [DIV_DATA_W-1:0] quo;
    } div_result_t;

    // Two's-complement negation, shared by operand magnitude and sign correction
    function automatic logic [DIV_DATA_W-1:0] div_neg(input logic [DIV_DATA_W-1:0] x);
        return ~x + DIV_DATA_W'(1);
    endfunction

    function automatic logic [DIV_DATA_W-1:0] div_mag(input logic [DIV_DATA_W-1:0] x,
                                                      input logic               is_signed);
        return (is_signed && x[DIV_DATA_W-1]) ? div_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial subtract of the divisor from the partial remainder.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DIV_WORK_W-1:0] i_work,
    input  logic [DIV_DATA_W-1:0] i_divisor,
    output logic [DIV_WORK_W-1:0] o_work
);

    logic [DIV_DATA_W:0] w_diff;
    logic                w_unused_msb;

    // The top bit only carries the shifted-out remainder bit; the step never reads it
    assign w_unused_msb = i_work[DIV_WORK_W-1];
    assign w_diff       = {1'b0, i_work[2*DIV_DATA_W-1:DIV_DATA_W]} - {1'b0, i_divisor};

    always_comb begin
        if (w_diff[DIV_DATA_W]) begin
            o_work = {i_work[2*DIV_DATA_W-1:0], 1'b0};
        end else begin
            o_work = {w_diff[DIV_DATA_W-1:0], i_work[DIV_DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; EX holds start_i high until ready_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e            r_state, w_state_nxt;
    logic [DIV_WORK_W-1:0] r_work, w_work_nxt, w_work_step;
    logic [DIV_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DIV_DATA_W-1:0] r_divisor, w_divisor_nxt;
    logic                  r_neg_quo, w_neg_quo_nxt;
    logic                  r_neg_rem, w_neg_rem_nxt;
    div_result_t           r_result, w_result_nxt;
    logic                  r_ready, w_ready_nxt;
    logic [DIV_DATA_W-1:0] w_quo_raw, w_rem_raw;

    div_step u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_work_step)
    );

    assign w_quo_raw = r_work[DIV_DATA_W-1:0];
    assign w_rem_raw = r_work[DIV_WORK_W-1:DIV_DATA_W+1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next datapath/output values
    always_comb begin
        w_state_nxt   = r_state;
        w_work_nxt    = r_work;
        w_cnt_nxt     = r_cnt;
        w_divisor_nxt = r_divisor;
        w_neg_quo_nxt = r_neg_quo;
        w_neg_rem_nxt = r_neg_rem;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            DIV_IDLE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = DIV_RESULT_ZERO;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DIV_BYZERO;
                    end else begin
                        w_neg_quo_nxt = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        w_neg_rem_nxt = signed_div_i && opdata1_i[DATA_W-1];
                        w_divisor_nxt = div_mag(opdata2_i, signed_div_i);
                        w_work_nxt    = {DIV_DATA_W'(0), div_mag(opdata1_i, signed_div_i), 1'b0};
                        w_cnt_nxt     = '0;
                        w_state_nxt   = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                w_result_nxt = DIV_RESULT_ZERO;
                w_ready_nxt  = 1'b1;
                w_state_nxt  = DIV_END;
            end
            DIV_ON: begin
                // A withdrawn or annulled request beats both the step and the finalize
                if (annul_i || !start_i) begin
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = DIV_RESULT_ZERO;
                    w_state_nxt  = DIV_IDLE;
                end else if (r_cnt == DIV_CNT_W'(DIV_STEPS)) begin
                    w_result_nxt.quo = r_neg_quo ? div_neg(w_quo_raw) : w_quo_raw;
                    w_result_nxt.rem = r_neg_rem ? div_neg(w_rem_raw) : w_rem_raw;
                    w_ready_nxt      = 1'b1;
                    w_state_nxt      = DIV_END;
                end else begin
                    w_work_nxt = w_work_step;
                    w_cnt_nxt  = r_cnt + DIV_CNT_W'(1);
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = DIV_RESULT_ZERO;
                    w_state_nxt  = DIV_IDLE;
                end
            end
            default: begin
                w_state_nxt = DIV_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= DIV_RESULT_ZERO;
            r_ready   <= 1'b0;
        end else begin
            r_work    <= w_work_nxt;
            r_cnt     <= w_cnt_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg_quo <= w_neg_quo_nxt;
            r_neg_rem <= w_neg_rem_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit: latency, signed/unsigned results, abort paths.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          checks;
    int          errors;
    logic [63:0] sb[$];
    logic [63:0] discard;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic avoids the 0x80000000/-1 overflow corner
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_l, q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            sa   = longint'($signed(a));
            sb_l = longint'($signed(b));
        end else begin
            sa   = longint'({32'd0, a});
            sb_l = longint'({32'd0, b});
        end
        q = sa / sb_l;
        r = sa % sb_l;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
    endtask

    // Drive a request and push its expected result; returns just after the accept edge
    task automatic start_req(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        sb.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        scramble();
    endtask

    // Count edges after accept until ready_o, then pop and compare the result
    task automatic wait_result(input string tag, input int exp_lat);
        int          n;
        logic        seen;
        logic [63:0] exp;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (ready_o === 1'b1) seen = 1'b1;
            else scramble();
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        chk({tag, "_res"}, result_o, exp);
    endtask

    task automatic release_req(input string tag);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
        chk({tag, "_rel_res"}, result_o, 64'h0);
    endtask

    task automatic full_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        start_req(s, a, b);
        wait_result(tag, (b == 32'd0) ? 1 : 33);
        release_req(tag);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", 64'(ready_o), 64'd0);
        chk("reset_res", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 100/7 with explicit expected value alongside the model
        chk("model_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        full_div("u100_7", 1'b0, 32'd100, 32'd7);

        full_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        full_div("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
        full_div("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        full_div("u_ovf",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        full_div("small",  1'b0, 32'd5, 32'd9);
        full_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

        // Divide by zero, then hold while start stays high
        start_req(1'b1, 32'd12345, 32'd0);
        wait_result("byzero", 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("byzero_hold_rdy", 64'(ready_o), 64'd1);
            chk("byzero_hold_res", result_o, 64'h0);
        end
        release_req("byzero");

        // Annul on the 10th ON cycle, then restart immediately
        start_req(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk("annul_on_rdy", 64'(ready_o), 64'd0);
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        chk("annul_rdy", 64'(ready_o), 64'd0);
        chk("annul_res", result_o, 64'h0);
        discard = sb.pop_front();
        @(negedge clk);
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd1;
        sb.push_back({32'd0, 32'hFFFF_FFFF});
        @(posedge clk);
        #1;
        scramble();
        wait_result("restart", 33);
        release_req("restart");

        // Synchronous reset while cnt==15
        start_req(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_rdy", 64'(ready_o), 64'd0);
        chk("rst_mid_res", result_o, 64'h0);
        discard = sb.pop_front();
        @(negedge clk);
        rst          = 1'b0;
        signed_div_i = 1'b1;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'hFFFF_FFF6;
        sb.push_back(model(1'b1, 32'd77, 32'hFFFF_FFF6));
        @(posedge clk);
        #1;
        scramble();
        wait_result("after_rst", 33);
        release_req("after_rst");

        // A few random operand pairs
        for (int i = 0; i < 4; i++) begin
            full_div("rand", 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 70000)));
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
